// File: rtl/wave_reader_if.sv
// rtl/wave_reader_if.sv - pixel stream from wave_reader to the display line builder
interface wave_reader_if;
    logic       px_valid;
    logic       px_ready;
    logic [9:0] px_x;
    logic [8:0] px_y;
    logic       frame_start;

    modport master (
        output px_valid,
        output px_x,
        output px_y,
        output frame_start,
        input  px_ready
    );

    modport slave (
        input  px_valid,
        input  px_x,
        input  px_y,
        input  frame_start,
        output px_ready
    );
endinterface

// File: rtl/wave_reader.sv
// rtl/wave_reader.sv - sample RAM reader producing one screen pixel per column; WAVE_READER_INVERT_EN flips px_y
module wave_reader #(
    parameter int ADDR_W     = 19,
    parameter int DATA_W     = 12,
    parameter int H_PIXELS   = 640,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              capture_done,
    input  logic [ADDR_W-1:0] trig_addr,
    input  logic [2:0]        time_div,
    output logic [ADDR_W-1:0] rdaddress,
    output logic              rden,
    input  logic [DATA_W-1:0] q,
    wave_reader_if.master     px,
    output logic              busy
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        step_q, step_d;
    logic [9:0]        col_q, col_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [8:0]        y_q, y_d;
    logic              valid_q, valid_d;
    logic              fs_q, fs_d;
    logic              rden_q, rden_d;
    logic              busy_q, busy_d;

    logic [8:0]        sample_y;
    logic              last_col;
    logic              unused_q_lsbs;

`ifdef WAVE_READER_INVERT_EN
    assign sample_y = 9'd511 - q[DATA_W-1 -: 9];
`else
    assign sample_y = q[DATA_W-1 -: 9];
`endif

    assign unused_q_lsbs = ^q[DATA_W-10:0];
    assign last_col      = (col_q == 10'(H_PIXELS - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        step_d  = step_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        valid_d = valid_q;
        fs_d    = fs_q;
        rden_d  = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            S_IDLE: begin
                if (capture_done) begin
                    addr_d  = trig_addr;
                    step_d  = 8'd1 << time_div;
                    col_d   = '0;
                    rden_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = CNT_W'(RD_LATENCY - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // cnt reaches zero in the cycle q carries the fetched sample
                if (cnt_q == '0) begin
                    y_d     = sample_y;
                    valid_d = 1'b1;
                    fs_d    = (col_q == '0);
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_OUT: begin
                if (px.px_ready) begin
                    valid_d = 1'b0;
                    fs_d    = 1'b0;
                    if (last_col) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        col_d   = col_q + 10'd1;
                        addr_d  = addr_q + ADDR_W'(step_q);
                        rden_d  = 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            step_q  <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
            fs_q    <= 1'b0;
            rden_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            step_q  <= step_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            valid_q <= valid_d;
            fs_q    <= fs_d;
            rden_q  <= rden_d;
            busy_q  <= busy_d;
        end
    end

    assign rdaddress      = addr_q;
    assign rden           = rden_q;
    assign busy           = busy_q;
    assign px.px_valid    = valid_q;
    assign px.px_x        = col_q;
    assign px.px_y        = y_q;
    assign px.frame_start = fs_q;

endmodule

// File: doc/wave_reader.md
# wave_reader

Read side of the oscilloscope sample RAM. After the capture path signals a completed acquisition, this block walks the stored 12-bit samples from a trigger address with a programmable decimation step. It converts each sample to a 9-bit screen ordinate and hands one pixel per column to the display line builder over a valid/ready handshake. It owns the RAM read port exclusively.

## Interface

Parameters:
- ADDR_W, 19, sample RAM address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 12, sample width
- H_PIXELS, 640, columns per frame
- RD_LATENCY, 2, RAM read latency in clk cycles, from the rden cycle to the q valid cycle

Ports:
- clk  in  1  system clock (100 MHz)
- rst_n  in  1  reset; asynchronous, active-low
- capture_done  in  1  one-cycle pulse: acquisition stored, RAM contents stable
- trig_addr  in  ADDR_W  address of first sample to display; sampled with capture_done
- time_div  in  3  decimation exponent; step = 1 << time_div; sampled with capture_done
- rdaddress  out  ADDR_W  RAM read address
- rden  out  1  RAM read enable, one cycle per fetch
- q  in  DATA_W  RAM read data
- px_valid  out  1  pixel available
- px_ready  in  1  consumer accepts the pixel when px_valid && px_ready
- px_x  out  10  column index 0..H_PIXELS-1
- px_y  out  9  screen ordinate
- frame_start  out  1  high with px_valid on column 0 only
- busy  out  1  high from acceptance of capture_done until the last pixel handshake

## Operation

- FSM states and transitions:
  - IDLE: on capture_done, latch base = trig_addr and step = 1 << time_div, clear col, go to READ.
  - READ: drive rden = 1 and rdaddress = base + col*step (mod 2^ADDR_W), go to WAIT.
  - WAIT: count RD_LATENCY cycles; on the cycle q is valid, register it, go to OUT.
  - OUT: hold px_valid with stable px_x/px_y/frame_start until the handshake.
    - Handshake with col < H_PIXELS-1: col++, go to READ.
    - Handshake with col = H_PIXELS-1: go to IDLE.
- px_y = q[11:3]; range 0..511.
- Address arithmetic: maintain an ADDR_W-bit running address incremented by step; no multiplier. Overflow wraps silently.
- capture_done in any state other than IDLE is ignored, with no latching and no restart.
- trig_addr and time_div are don't-care except in the capture_done cycle while in IDLE.
- rden is never asserted outside READ. Exactly one read is issued per pixel.

## Timing

- Reset values: rdaddress=0, rden=0, px_valid=0, px_x=0, px_y=0, frame_start=0, busy=0; FSM = IDLE.
- Reset mid-frame: all outputs return to their reset values asynchronously. No pixel completes. The next frame requires a new capture_done.
- capture_done at edge N: busy=1 and rden=1 at N+1; px_valid=1 at N+1+RD_LATENCY+1 (N+4 at default).
- Per-pixel cost: 1 (READ) + RD_LATENCY + 1 (OUT) cycles with px_ready held high. That is 4 cycles at default, or 2560 cycles per 640-pixel frame.
- px_ready low: the block stalls in OUT indefinitely; outputs do not change.
- After the final handshake: busy=0 and px_valid=0 on the next cycle. A capture_done in that same cycle (now IDLE) is accepted.
- px_ready is ignored while px_valid=0.

## Configuration

- WAVE_READER_INVERT_EN defined: px_y = 511 - q[11:3], so full-scale input maps to row 0 (top of screen).
- Not defined: px_y = q[11:3], with no inversion logic present.

## Test plan

- Reset with rst_n low while clk runs, and mid-frame at pixel 100 -> all outputs take their reset values immediately; busy=0; no further rden until a new capture_done.
- RAM model with latency 2 and mem[a] = a[11:0], trig_addr=0, time_div=0, px_ready=1 -> 640 pixels with px_x=0..639, px_y=px_x>>3, frame_start only on x=0, exactly 640 rden pulses, 4 cycles per pixel.
- trig_addr=19'h7FFF0, time_div=3 -> rdaddress sequence 7FFF0, 7FFF8, 00000, 00008, ... (wrap); pixel 639 read from address (7FFF0 + 639*8) mod 2^19 = 0x013E8.
- px_ready held low 50 cycles at pixel 5, then pulsed per pixel -> px_x/px_y stable during the stall; no rden during the stall; no pixel dropped or duplicated.
- Constant q = 12'd2012, capture_done pulsed again at pixel 300 -> second pulse ignored; all px_y = 251 (or 260 with WAVE_READER_INVERT_EN); busy falls after pixel 639.
- capture_done coincident with the cycle after the final handshake -> the new frame starts, and rden fires on the following cycle.
